// File: rtl/alu_cmd_driver.sv
// Host-command initiator for the ALU pin interface: issues one op, samples the result,
// services the irq and returns a response. Optional counters: ALU_CMD_DRIVER_STATS_EN.
module alu_cmd_driver #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned RESULT_LAT  = 1,
  parameter int unsigned IRQ_CLR_MAX = 4
) (
  input  logic              alu_clk,
  input  logic              alu_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_unit,
  input  logic [1:0]        cmd_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_irq,
  output logic              rsp_irq_stuck,
  output logic              alu_enable,
  output logic              alu_enable_a,
  output logic              alu_enable_b,
  output logic [DATA_W-1:0] alu_in_a,
  output logic [DATA_W-1:0] alu_in_b,
  output logic [1:0]        alu_op_a,
  output logic [1:0]        alu_op_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_irq,
  output logic              alu_irq_clr
`ifdef ALU_CMD_DRIVER_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_irqs
`endif
);

  localparam int unsigned CNT_MAX = (RESULT_LAT > IRQ_CLR_MAX) ? RESULT_LAT : IRQ_CLR_MAX;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_IRQ_CLR,
    S_IRQ_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Outputs are registered on state entry, so each state's outputs are set by the edge that enters it.
  always_ff @(posedge alu_clk) begin
    if (alu_rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_irq       <= 1'b0;
      rsp_irq_stuck <= 1'b0;
      alu_enable    <= 1'b0;
      alu_enable_a  <= 1'b0;
      alu_enable_b  <= 1'b0;
      alu_in_a      <= '0;
      alu_in_b      <= '0;
      alu_op_a      <= 2'b00;
      alu_op_b      <= 2'b00;
      alu_irq_clr   <= 1'b0;
    end else begin
      alu_enable   <= 1'b0;
      alu_enable_a <= 1'b0;
      alu_enable_b <= 1'b0;
      alu_irq_clr  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            alu_in_a     <= cmd_a;
            alu_in_b     <= cmd_b;
            alu_op_a     <= cmd_unit ? 2'b00 : cmd_op;
            alu_op_b     <= cmd_unit ? cmd_op : 2'b00;
            alu_enable   <= 1'b1;
            alu_enable_a <= ~cmd_unit;
            alu_enable_b <= cmd_unit;
            cmd_ready    <= 1'b0;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= CNT_W'(RESULT_LAT);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            rsp_data      <= alu_out;
            rsp_irq       <= alu_irq;
            rsp_irq_stuck <= 1'b0;
            if (alu_irq) begin
              alu_irq_clr <= 1'b1;
              state       <= S_IRQ_CLR;
            end else begin
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_IRQ_CLR: begin
          cnt   <= CNT_W'(IRQ_CLR_MAX);
          state <= S_IRQ_WAIT;
        end
        S_IRQ_WAIT: begin
          if (!alu_irq) begin
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (cnt == CNT_W'(1)) begin
            rsp_irq_stuck <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= S_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_CMD_DRIVER_STATS_EN
  // Saturating response counters; clear wins over a same-cycle increment.
  always_ff @(posedge alu_clk) begin
    if (alu_rst || stat_clr) begin
      stat_ops  <= 16'h0000;
      stat_irqs <= 16'h0000;
    end else if (state == S_RESP && rsp_ready) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (rsp_irq && stat_irqs != 16'hFFFF) stat_irqs <= stat_irqs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: directed scenarios plus randomized traffic against a
// cycle-timestamp reference model of the command/response protocol.
module tb_alu_cmd_driver;

  localparam int unsigned DW     = 8;
  localparam int unsigned LAT    = 1;
  localparam int unsigned CLRMAX = 4;
  localparam int          INF    = 32'h7fffffff;

  logic          clk = 1'b0;
  logic          alu_rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [DW-1:0] cmd_a = '0, cmd_b = '0;
  logic          cmd_unit = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_irq, rsp_irq_stuck;
  logic          alu_enable, alu_enable_a, alu_enable_b;
  logic [DW-1:0] alu_in_a, alu_in_b;
  logic [1:0]    alu_op_a, alu_op_b;
  logic [DW-1:0] alu_out = '0;
  logic          alu_irq = 1'b0;
  logic          alu_irq_clr;
`ifdef ALU_CMD_DRIVER_STATS_EN
  logic          stat_clr = 1'b0;
  logic [15:0]   stat_ops, stat_irqs;
  bit            stat_clr_v = 1'b0;
  int unsigned   m_ops = 0, m_irqs = 0;
`endif

  always #5 clk = ~clk;

  alu_cmd_driver #(.DATA_W(DW), .RESULT_LAT(LAT), .IRQ_CLR_MAX(CLRMAX)) dut (
    .alu_clk(clk), .alu_rst(alu_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_unit(cmd_unit), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_irq(rsp_irq), .rsp_irq_stuck(rsp_irq_stuck),
    .alu_enable(alu_enable), .alu_enable_a(alu_enable_a), .alu_enable_b(alu_enable_b),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_out(alu_out), .alu_irq(alu_irq), .alu_irq_clr(alu_irq_clr)
`ifdef ALU_CMD_DRIVER_STATS_EN
    , .stat_clr(stat_clr), .stat_ops(stat_ops), .stat_irqs(stat_irqs)
`endif
  );

  int total = 0, bad = 0, cyc = 0;
  bit known = 1'b0;

  // Reference model: one outstanding op described by the cycle numbers of its events.
  bit            m_busy = 1'b0, m_unit = 1'b0, m_irq = 1'b0, m_stuck = 1'b0;
  logic [1:0]    m_op = 2'b00;
  logic [DW-1:0] m_a = '0, m_b = '0, m_data = '0;
  int            m_en = -1, m_s = -1, m_rs = INF;

  // Observations for the directed literal checks.
  int            en_cnt, clr_cnt, vld_cnt, first_valid, acc_cyc, first_hs;
  logic [DW-1:0] seen_data;
  bit            seen_irq, seen_stuck, prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic clr_obs();
    en_cnt = 0; clr_cnt = 0; vld_cnt = 0; first_valid = -1; acc_cyc = -1; first_hs = -1;
    seen_data = '0; seen_irq = 1'b0; seen_stuck = 1'b0;
  endtask

  task automatic step(input bit rst, input bit v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input bit u, input logic [1:0] op, input bit rdy,
                      input logic [DW-1:0] out, input bit irq);
    bit en_x, vld_x;
    @(negedge clk);
    alu_rst = rst; cmd_valid = v; cmd_a = a; cmd_b = b; cmd_unit = u; cmd_op = op;
    rsp_ready = rdy; alu_out = out; alu_irq = irq;
`ifdef ALU_CMD_DRIVER_STATS_EN
    stat_clr = stat_clr_v;
`endif
    #1;
    if (known) begin
      en_x  = m_busy && cyc == m_en;
      vld_x = m_busy && cyc >= m_rs;
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      chk("alu_enable", 32'(alu_enable), 32'(en_x));
      chk("alu_enable_a", 32'(alu_enable_a), 32'(en_x && !m_unit));
      chk("alu_enable_b", 32'(alu_enable_b), 32'(en_x && m_unit));
      chk("alu_in_a", 32'(alu_in_a), 32'(m_a));
      chk("alu_in_b", 32'(alu_in_b), 32'(m_b));
      chk("alu_op_a", 32'(alu_op_a), 32'(m_unit ? 2'b00 : m_op));
      chk("alu_op_b", 32'(alu_op_b), 32'(m_unit ? m_op : 2'b00));
      chk("alu_irq_clr", 32'(alu_irq_clr), 32'(m_busy && m_irq && cyc == m_s + 1));
      chk("rsp_valid", 32'(rsp_valid), 32'(vld_x));
      if (vld_x) begin
        chk("rsp_data", 32'(rsp_data), 32'(m_data));
        chk("rsp_irq", 32'(rsp_irq), 32'(m_irq));
        chk("rsp_irq_stuck", 32'(rsp_irq_stuck), 32'(m_stuck));
      end
`ifdef ALU_CMD_DRIVER_STATS_EN
      chk("stat_ops", 32'(stat_ops), m_ops);
      chk("stat_irqs", 32'(stat_irqs), m_irqs);
`endif
    end
    if (alu_enable === 1'b1) en_cnt++;
    if (alu_irq_clr === 1'b1) clr_cnt++;
    if (rsp_valid === 1'b1) begin
      vld_cnt++;
      if (!prev_valid && first_valid < 0) begin
        first_valid = cyc; seen_data = rsp_data; seen_irq = rsp_irq; seen_stuck = rsp_irq_stuck;
      end
      if (rdy && first_hs < 0) first_hs = cyc;
    end
    prev_valid = (rsp_valid === 1'b1);
    if (cmd_ready === 1'b1 && v && !rst) acc_cyc = cyc;
    // Advance the model across the coming clock edge.
    if (rst) begin
      m_busy = 1'b0; m_a = '0; m_b = '0; m_op = 2'b00; m_unit = 1'b0; m_irq = 1'b0;
      m_rs = INF; known = 1'b1;
`ifdef ALU_CMD_DRIVER_STATS_EN
      m_ops = 0; m_irqs = 0;
`endif
    end else begin
      if (!m_busy) begin
        if (v) begin
          m_busy = 1'b1; m_a = a; m_b = b; m_unit = u; m_op = op;
          m_en = cyc + 1; m_s = cyc + 1 + LAT; m_rs = INF; m_irq = 1'b0; m_stuck = 1'b0;
        end
      end else begin
        if (cyc == m_s) begin
          m_data = out; m_irq = irq;
          if (!irq) m_rs = cyc + 1;
        end else if (m_irq && m_rs == INF && cyc >= m_s + 2) begin
          if (!irq) m_rs = cyc + 1;
          else if (cyc == m_s + 1 + CLRMAX) begin m_stuck = 1'b1; m_rs = cyc + 1; end
        end
        if (m_rs != INF && cyc >= m_rs && rdy) begin
          m_busy = 1'b0;
`ifdef ALU_CMD_DRIVER_STATS_EN
          if (m_ops != 32'hFFFF) m_ops++;
          if (m_irq && m_irqs != 32'hFFFF) m_irqs++;
`endif
        end
      end
`ifdef ALU_CMD_DRIVER_STATS_EN
      if (stat_clr_v) begin m_ops = 0; m_irqs = 0; end
`endif
    end
    cyc++;
  endtask

  initial begin
    bit            irq_lvl;
    int            irq_run;
    bit            rdy_lvl;
    int            rdy_run;

    // Reset held 3 cycles with a command pending: no enable may appear.
    clr_obs();
    for (int k = 0; k < 3; k++) step(1, 1, 8'h0F, 8'h01, 0, 2'b01, 1, 8'h10, 0);
    chk("reset_no_enable", 32'(en_cnt), 32'd0);

    // Unit A op 01, result 8'h10, no irq.
    clr_obs();
    for (int k = 0; k < 6; k++) step(0, k == 0, 8'h0F, 8'h01, 0, 2'b01, 1, 8'h10, 0);
    chk("t2_en_pulses", 32'(en_cnt), 32'd1);
    chk("t2_rsp_latency", 32'(first_valid - acc_cyc), 32'd3);
    chk("t2_rsp_data", 32'(seen_data), 32'h10);
    chk("t2_rsp_irq", 32'(seen_irq), 32'd0);

    // Unit B, irq at sample drops two cycles after the clear pulse.
    clr_obs();
    for (int k = 0; k < 10; k++)
      step(0, k == 0, 8'h55, 8'h33, 1, 2'b11, 1, 8'(8'hA0 + k), k >= 2 && k <= 4);
    chk("t3_clr_pulses", 32'(clr_cnt), 32'd1);
    chk("t3_rsp_data", 32'(seen_data), 32'hA2);
    chk("t3_rsp_irq", 32'(seen_irq), 32'd1);
    chk("t3_rsp_stuck", 32'(seen_stuck), 32'd0);

    // Stuck irq: one clear, then the timeout produces a stuck response.
    clr_obs();
    for (int k = 0; k < 12; k++) step(0, k == 0, 8'h12, 8'h34, 0, 2'b10, 1, 8'h77, k >= 2);
    chk("t4_clr_pulses", 32'(clr_cnt), 32'd1);
    chk("t4_rsp_latency", 32'(first_valid - acc_cyc), 32'd8);
    chk("t4_rsp_irq", 32'(seen_irq), 32'd1);
    chk("t4_rsp_stuck", 32'(seen_stuck), 32'd1);

    // Backpressure: response held 5 cycles while a second command waits.
    clr_obs();
    for (int k = 0; k < 14; k++)
      step(0, k <= 9, 8'(k), 8'h0C, 0, 2'b00, k >= 8, 8'(8'h40 + k), 0);
    chk("t5_second_accept", 32'(acc_cyc - first_hs), 32'd1);
    chk("t5_valid_cycles", 32'(vld_cnt), 32'd7);

    // Reset during WAIT aborts the op without a response.
    clr_obs();
    for (int k = 0; k < 6; k++) step(k == 2, k == 0, 8'hEE, 8'h11, 1, 2'b01, 1, 8'h99, 0);
    chk("t6_no_response", 32'(vld_cnt), 32'd0);
    chk("t6_en_pulses", 32'(en_cnt), 32'd1);
`ifdef ALU_CMD_DRIVER_STATS_EN
    chk("t6_stat_after_abort", 32'(stat_ops), 32'd0);
    for (int k = 0; k < 5; k++) step(0, k == 0, 8'h01, 8'h02, 0, 2'b11, 1, 8'h03, 0);
    chk("t6_stat_after_op", 32'(stat_ops), 32'd1);
`endif

    // Randomized traffic with run-length irq and backpressure patterns.
    irq_lvl = 1'b0; irq_run = 0; rdy_lvl = 1'b1; rdy_run = 0;
    for (int i = 0; i < 4000; i++) begin
      if (irq_run == 0) begin irq_lvl = ($urandom_range(0, 2) == 0); irq_run = $urandom_range(1, 9); end
      if (rdy_run == 0) begin rdy_lvl = ($urandom_range(0, 3) != 0); rdy_run = $urandom_range(1, 6); end
      irq_run--; rdy_run--;
`ifdef ALU_CMD_DRIVER_STATS_EN
      stat_clr_v = ($urandom_range(0, 199) == 0);
`endif
      step($urandom_range(0, 399) == 0, $urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom),
           1'($urandom), 2'($urandom), rdy_lvl, 8'($urandom), irq_lvl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Synthesizable initiator for the ALU pin interface; the control side of the interface the ALU responds on.
- Takes a host command (operands, unit select, opcode) on a valid/ready port.
- Drives one ALU operation, samples the result after a fixed latency, services the ALU interrupt with an irq-clear pulse, and returns result and status on a valid/ready response port.
- Sits between a host/sequencer and the alu instance; serves as the RTL stimulus engine for emulation-style benches.

Parameters:
- DATA_W, 8, width of operands and ALU result.
- RESULT_LAT, 1, cycles from the enable pulse to the alu_out/alu_irq sample point (1..15).
- IRQ_CLR_MAX, 4, cycles allowed for alu_irq to drop after the clear pulse before the stuck flag is set.

Ports:
- alu_clk  in  1  clock; all logic on the rising edge.
- alu_rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  driver can accept a command.
- cmd_a  in  DATA_W  operand A.
- cmd_b  in  DATA_W  operand B.
- cmd_unit  in  1  0 = op group A, 1 = op group B.
- cmd_op  in  2  opcode within the selected group.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts the response.
- rsp_data  out  DATA_W  captured alu_out.
- rsp_irq  out  1  ALU raised irq for this operation.
- rsp_irq_stuck  out  1  irq did not clear within IRQ_CLR_MAX.
- alu_enable, alu_enable_a, alu_enable_b  out  1 each  ALU enables.
- alu_in_a, alu_in_b  out  DATA_W  ALU operands.
- alu_op_a, alu_op_b  out  2 each  ALU opcodes.
- alu_out  in  DATA_W  ALU result.
- alu_irq  in  1  ALU interrupt.
- alu_irq_clr  out  1  interrupt clear pulse.

Behaviour:
- Interface: one clock, alu_clk. Reset alu_rst is synchronous and active-high.
- Reset values: all outputs 0 except cmd_ready = 1. State goes to IDLE. Reset mid-operation aborts immediately; no response is produced for the aborted command.
- Registered outputs: all ALU-facing outputs are registered.
  - alu_in_a, alu_in_b, alu_op_a, alu_op_b hold their last value until the next command is accepted.
  - The op field of the unselected unit is driven 0.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, register operands, unit and opcode, then go to ISSUE.
  - cmd_ready is 0 in every other state; cmd_valid is ignored there.
- ISSUE (1 cycle):
  - alu_enable = 1.
  - alu_enable_a = ~unit, alu_enable_b = unit.
  - Load the latency counter with RESULT_LAT, then go to WAIT.
- WAIT:
  - All enables are 0; the counter decrements each cycle.
  - In the cycle where the counter reaches 1, sample alu_out into rsp_data and alu_irq into the irq flag.
  - Next state: IRQ_CLR if irq was sampled, else RESP.
  - Timing: command accepted at edge T, enables high in cycle T+1, sample at edge T+1+RESULT_LAT.
- IRQ_CLR:
  - alu_irq_clr = 1 for exactly one cycle, then go to IRQ_WAIT with the timeout counter = IRQ_CLR_MAX.
- IRQ_WAIT:
  - If alu_irq == 0, go to RESP.
  - If the counter expires with irq still high, set the stuck flag and go to RESP.
  - No second clear pulse is issued.
- RESP:
  - rsp_valid = 1; rsp_data, rsp_irq, rsp_irq_stuck are held stable.
  - On rsp_ready, drop rsp_valid and go to IDLE.
  - rsp_ready while rsp_valid = 0 has no effect.
- Latency, no irq, rsp_ready tied high: rsp_valid asserts RESULT_LAT+2 cycles after acceptance. Next command can be accepted in the cycle after the response handshake.
- alu_irq asserted outside WAIT/IRQ_WAIT is ignored.

Optional Feature:
- Macro: ALU_CMD_DRIVER_STATS_EN.
- When defined, adds:
  - output stat_ops [15:0]: increments on each response handshake.
  - output stat_irqs [15:0]: increments on each response with rsp_irq = 1.
  - input stat_clr: synchronous clear of both counters; takes priority over an increment in the same cycle.
  - Counters saturate at 16'hFFFF and clear on alu_rst.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset held 3 cycles with cmd_valid = 1 → cmd_ready = 1, all ALU outputs 0, no enable pulse. First enable appears only after reset is released.
2. Unit A, op 2'b01, a = 8'h0F, b = 8'h01, RESULT_LAT = 1, alu_out = 8'h10 at the sample point, rsp_ready = 1 → alu_enable and alu_enable_a high exactly 1 cycle; rsp_valid high 3 cycles after acceptance; rsp_data = 8'h10, rsp_irq = 0.
3. Unit B with alu_irq = 1 at the sample point, dropping 2 cycles after the clear → one-cycle alu_irq_clr; rsp_irq = 1, rsp_irq_stuck = 0.
4. alu_irq stuck high → single clear pulse; after IRQ_CLR_MAX = 4 cycles, response arrives with rsp_irq = 1, rsp_irq_stuck = 1.
5. rsp_ready held 0 for 5 cycles while a second cmd_valid is pending → rsp_valid and rsp_data stable, cmd_ready = 0. Second command accepted in the cycle after the handshake.
6. alu_rst pulsed during WAIT → outputs return to reset values next cycle, no rsp_valid. With ALU_CMD_DRIVER_STATS_EN, stat_ops is unchanged by the aborted op and increments once for each subsequent completed op.
